// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: valid/ready on both sides, 2-entry skid buffer, synchronous flush.
// Define PIPE_STAGE_STATS_EN to build the saturating stall/bubble counters; otherwise they read 0.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] head, head_nxt;
  logic [WIDTH-1:0] skid, skid_nxt;
  logic             accept, emit;

  // All handshake outputs decode from registered state only, so in_* never reaches out_*.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    case (state)
      HALF:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    if (flush) begin
      state_nxt = EMPTY;
      head_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = HALF;
            head_nxt  = in_data;
          end
        end
        HALF: begin
          if (accept && !emit) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (accept && emit) begin
            head_nxt  = in_data;
          end else if (emit) begin
            state_nxt = EMPTY;
            head_nxt  = '0;
          end
        end
        FULL: begin
          if (emit) begin
            state_nxt = HALF;
            head_nxt  = skid;
            skid_nxt  = '0;
          end
        end
        default: begin
          state_nxt = EMPTY;
          head_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: data registers are reset too, because an empty entry must read as all-zero on out_data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state <= state_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Counters saturate instead of wrapping and survive flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (!out_valid && out_ready && (bubble_cycles != '1))
        bubble_cycles <= bubble_cycles + CNT_W'(1);
    end
  end
`else
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: driver pushes accepted words, monitor pops and compares
// against a FIFO-of-at-most-two reference model plus saturating counter models.
module tb_pipe_stage_buf;
  localparam int WIDTH   = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cycles, bubble_cycles;

  pipe_stage_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );

  always #5 clock = ~clock;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_bubble = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive after the edge, record an accepted word in the scoreboard.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    logic acc;
    @(posedge clock);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (exp_q.size() < 2);
    #2;
    if (acc && !fl && reset_n) exp_q.push_back(d);
  endtask

  // Monitor: compares outputs at posedge+2, then advances the model for the coming edge.
  initial begin
    int sz;
    logic [31:0] exp_head;
    forever begin
      @(posedge clock);
      #2;
      if (reset_n) begin
        sz = exp_q.size();
        exp_head = (sz > 0) ? exp_q[0] : 32'h0;
        check("occupancy", 32'(occupancy), 32'(sz));
        check("out_valid", 32'(out_valid), 32'(sz > 0));
        check("in_ready", 32'(in_ready), 32'(sz < 2));
        check("out_data", out_data, exp_head);
`ifdef PIPE_STAGE_STATS_EN
        check("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
        check("bubble_cycles", 32'(bubble_cycles), 32'(exp_bubble));
`else
        check("stall_cycles", 32'(stall_cycles), 32'h0);
        check("bubble_cycles", 32'(bubble_cycles), 32'h0);
`endif
        if (sz > 0 && !out_ready && exp_stall < CNT_MAX) exp_stall++;
        if (sz == 0 && out_ready && exp_bubble < CNT_MAX) exp_bubble++;
        if (sz > 0 && out_ready) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Streaming at full throughput: occupancy stays at 1.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h13 + 32'(i), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill the skid, offer C while full, then drain: only A, B come out.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while HALF with a same-cycle transfer: 6 must be dropped.
    cycle(1'b1, 32'h5, 1'b0, 1'b0);
    cycle(1'b1, 32'h6, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Hold FULL with downstream stalled long enough to saturate the stall counter.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
`ifdef PIPE_STAGE_STATS_EN
    check("stall_saturated", 32'(stall_cycles), 32'(CNT_MAX));
`else
    check("stall_disabled", 32'(stall_cycles), 32'h0);
`endif

    // Asynchronous reset between edges while FULL.
    @(posedge clock);
    #4;
    reset_n = 1'b0;
    exp_q.delete();
    exp_stall = 0;
    exp_bubble = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_occupancy", 32'(occupancy), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_stall", 32'(stall_cycles), 32'h0);
    check("rst_bubble", 32'(bubble_cycles), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    @(posedge clock);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
